encrypt: RTL and testbench
==========================

# encrypt

Upstream stage of the LWE decrypt path. Accepts a plaintext and a random subset selector, walks the stored public key of BIG_N samples (a_i, b_i), and accumulates the ciphertext pair `cipher_text_top` / `cipher_text_bot` modulo CIPHERTEXT_MODULUS. The result drives the decrypt stage's ciphertext inputs directly through a valid/ready handshake. Runtime is constant, independent of plaintext and subset mask.

## Interface
- PLAINTEXT_MODULUS, 64, plaintext modulus p (= 2^PLAINTEXT_WIDTH)
- PLAINTEXT_WIDTH, 6, plaintext bits
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q (= 2^CIPHERTEXT_WIDTH)
- CIPHERTEXT_WIDTH, 10, ciphertext bits
- BIG_N, 30, number of public-key samples
- ADDR_WIDTH, 5, public-key address bits (≥ clog2(BIG_N))

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- plaintext  in  PLAINTEXT_WIDTH  message m, sampled on the input handshake
- subset_mask  in  BIG_N  bit i selects sample i, sampled on the input handshake
- pk_rd_en  out  1  public-key read strobe
- pk_addr  out  ADDR_WIDTH  sample index
- pk_a  in  CIPHERTEXT_WIDTH  a_i, valid the cycle after pk_rd_en
- pk_b  in  CIPHERTEXT_WIDTH  b_i, valid the cycle after pk_rd_en
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts
- cipher_text_top  out  signed CIPHERTEXT_WIDTH  sum(b_i) + m·2^(CW−PW) mod q
- cipher_text_bot  out  signed CIPHERTEXT_WIDTH  sum(a_i) mod q
- busy  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, ISSUE, DRAIN, OUT.
- **IDLE:** `in_ready=1`. When `in_valid`:
  - latch `subset_mask`
  - set acc_top = plaintext << (CIPHERTEXT_WIDTH−PLAINTEXT_WIDTH), truncated to CW bits
  - set acc_bot = 0 and idx = 0
  - go to ISSUE
- **ISSUE:**
  - `pk_rd_en=1`, `pk_addr=idx`, idx++
  - after issuing idx = BIG_N−1, go to DRAIN
- **Accumulate:** applies every cycle in which the previous cycle issued a read, in both ISSUE and DRAIN. If the mask bit of the returned index is 1, then acc_top += pk_b and acc_bot += pk_a.
  - All additions are unsigned CW-bit, wrapping modulo 2^CW; the carry is discarded.
  - Mask bit 0 means no change.
- **DRAIN:** `pk_rd_en=0`. Performs the final accumulate, then goes to OUT.
- **OUT:**
  - `out_valid=1`; `cipher_text_top` and `cipher_text_bot` are registered copies of the accumulators.
  - Outputs hold stable while `out_ready=0`.
  - On `out_valid && out_ready`, go to IDLE.
- Reads are always issued for all BIG_N indices, regardless of mask (constant time). The mask only gates accumulation.
- Output ports are raw two's-complement residues. There is no reduction beyond truncation.
- `in_valid` outside IDLE is ignored. `plaintext` and `subset_mask` are not re-sampled.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so `in_ready=1` and `busy=0`
  - `out_valid=0`, `pk_rd_en=0`, `pk_addr=0`
  - `cipher_text_top=0`, `cipher_text_bot=0`, accumulators 0
- Input handshake at cycle T:
  - `pk_rd_en` is high for cycles T+1..T+BIG_N with `pk_addr` 0..BIG_N−1 in order
  - DRAIN at T+BIG_N+1
  - `out_valid` rises at T+BIG_N+2
- Latency from accept to `out_valid` is BIG_N+2 cycles. Minimum initiation interval is BIG_N+3 cycles.
- `in_ready` is low in the output-handshake cycle. The next accept is at the earliest one cycle later.
- Reset mid-ISSUE or mid-OUT aborts the transaction with no output. Public-key data returning after reset is ignored.

## Test plan
Memory model: a_i = i+1, b_i = 2(i+1), 1-cycle read latency; default parameters.
- **All samples:** mask all ones, m=0 → bot=465, top=930.
- **Empty subset:** mask 0, m=5 → top=80, bot=0; `pk_rd_en` still high for exactly 30 cycles.
- **Wrap-around:** mask=0x2000_0001, m=63 → top=(1008+2+60) mod 1024=46, bot=31.
- **Latency and addressing:** accept at T → `pk_addr` 0..29 on T+1..T+30, `out_valid` at T+32; repeat with random masks → identical timing.
- **Backpressure:** hold `out_ready=0` for 10 cycles in OUT → outputs stable, `in_ready=0`, extra `in_valid` ignored; release → handshake, `in_ready=1` next cycle.
- **Reset mid-operation:** assert `rst_n=0` while `pk_addr=12` → all outputs at reset values immediately; after release, mask all ones, m=1 → top=(930+16)=946, bot=465.

Source files
------------

// File: rtl/encrypt.sv
// LWE encryption front end: walks all BIG_N public-key samples in constant time and
// accumulates the subset-selected (a_i, b_i) into the ciphertext pair modulo q.
module encrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int BIG_N              = 30,
    parameter int ADDR_WIDTH         = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PLAINTEXT_WIDTH-1:0]         plaintext,
    input  logic [BIG_N-1:0]                   subset_mask,
    output logic                               pk_rd_en,
    output logic [ADDR_WIDTH-1:0]              pk_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0]        pk_a,
    input  logic [CIPHERTEXT_WIDTH-1:0]        pk_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [CIPHERTEXT_WIDTH-1:0] cipher_text_top,
    output logic signed [CIPHERTEXT_WIDTH-1:0] cipher_text_bot,
    output logic                               busy
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // ISSUE | one public-key read per cycle, indices 0..BIG_N-1
    // DRAIN | last read returns, final accumulate, capture result
    // OUT   | ciphertext presented until out_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int CW = CIPHERTEXT_WIDTH;
    localparam int PW = PLAINTEXT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BIG_N - 1);

    if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) ||
        CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) ||
        PLAINTEXT_WIDTH >= CIPHERTEXT_WIDTH ||
        (1 << ADDR_WIDTH) < BIG_N) begin : g_bad_params
        $error("encrypt: inconsistent parameters");
    end

    logic [1:0]          state;
    logic [BIG_N-1:0]    mask;
    logic [CW-1:0]       acc_top;
    logic [CW-1:0]       acc_bot;
    logic [CW-1:0]       acc_top_nxt;
    logic [CW-1:0]       acc_bot_nxt;
    logic                rd_pend;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [CW-1:0]       ct_top;
    logic [CW-1:0]       ct_bot;

    // Data for the read issued last cycle is on pk_a/pk_b now; rd_pend/rd_idx track it.
    always_comb begin
        acc_top_nxt = acc_top;
        acc_bot_nxt = acc_bot;
        if (rd_pend && mask[rd_idx]) begin
            acc_top_nxt = acc_top + pk_b;
            acc_bot_nxt = acc_bot + pk_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mask     <= '0;
            acc_top  <= '0;
            acc_bot  <= '0;
            rd_pend  <= 1'b0;
            rd_idx   <= '0;
            pk_rd_en <= 1'b0;
            pk_addr  <= '0;
            ct_top   <= '0;
            ct_bot   <= '0;
        end else begin
            rd_pend <= pk_rd_en;
            rd_idx  <= pk_addr;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mask     <= subset_mask;
                        acc_top  <= {plaintext, {(CW - PW){1'b0}}};
                        acc_bot  <= '0;
                        pk_rd_en <= 1'b1;
                        pk_addr  <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    acc_top <= acc_top_nxt;
                    acc_bot <= acc_bot_nxt;
                    if (pk_addr == LAST_ADDR) begin
                        pk_rd_en <= 1'b0;
                        pk_addr  <= '0;
                        state    <= S_DRAIN;
                    end else begin
                        pk_addr <= pk_addr + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    acc_top <= acc_top_nxt;
                    acc_bot <= acc_bot_nxt;
                    ct_top  <= acc_top_nxt;
                    ct_bot  <= acc_bot_nxt;
                    state   <= S_OUT;
                end
                default: begin
                    if (out_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (state == S_IDLE);
    assign busy            = (state != S_IDLE);
    assign out_valid       = (state == S_OUT);
    assign cipher_text_top = ct_top;
    assign cipher_text_bot = ct_bot;

endmodule

// File: tb/tb_encrypt.sv
// Scoreboard bench for encrypt: randomized and directed requests against a
// sum-over-subset reference model with a 1-cycle public-key memory (a_i=i+1, b_i=2(i+1)).
module tb_encrypt;
    localparam int N     = 30;
    localparam int PW    = 6;
    localparam int CW    = 10;
    localparam int AW    = 5;
    localparam int Q     = 1024;
    localparam int SCALE = Q / 64;

    typedef struct packed {
        logic [CW-1:0] top;
        logic [CW-1:0] bot;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PW-1:0]        plaintext = '0;
    logic [N-1:0]         subset_mask = '0;
    logic                 pk_rd_en;
    logic [AW-1:0]        pk_addr;
    logic [CW-1:0]        pk_a = '0;
    logic [CW-1:0]        pk_b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [CW-1:0] cipher_text_top;
    logic signed [CW-1:0] cipher_text_bot;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    encrypt dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .subset_mask(subset_mask),
        .pk_rd_en(pk_rd_en), .pk_addr(pk_addr), .pk_a(pk_a), .pk_b(pk_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .cipher_text_top(cipher_text_top), .cipher_text_bot(cipher_text_bot),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pk_rd_en) begin
            pk_a <= CW'(int'(pk_addr) + 1);
            pk_b <= CW'(2 * (int'(pk_addr) + 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] mask, input logic [PW-1:0] m);
        int t = int'(m) * SCALE;
        int b = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                t += 2 * (i + 1);
                b += i + 1;
            end
        end
        model.top = CW'(t % Q);
        model.bot = CW'(b % Q);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ct_unexpected actual top %0d bot %0d required none",
                         cipher_text_top, cipher_text_bot);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ct_top", 64'(unsigned'(cipher_text_top)), 64'(e.top));
                check("ct_bot", 64'(unsigned'(cipher_text_bot)), 64'(e.bot));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic launch(input logic [N-1:0] mask, input logic [PW-1:0] m, input bit expect_out);
        wait_ready();
        in_valid    = 1'b1;
        plaintext   = m;
        subset_mask = mask;
        if (expect_out) sb.push_back(model(mask, m));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        plaintext   = PW'($urandom);
        subset_mask = N'($urandom);
    endtask

    task automatic do_txn(input logic [N-1:0] mask, input logic [PW-1:0] m, input bit bp);
        int bad = 0;
        logic [2*CW-1:0] cap;
        launch(mask, m, 1'b1);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (!pk_rd_en || int'(pk_addr) != k || out_valid) bad++;
        end
        check("issue_addr_seq_errs", 64'(bad), 0);
        @(negedge clk);
        check("drain_rd_valid_busy", {61'd0, pk_rd_en, out_valid, busy}, 64'b001);
        if (bp) out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_latency", 64'(out_valid), 1);
        if (bp) begin
            cap = {cipher_text_top, cipher_text_bot};
            in_valid    = 1'b1;
            plaintext   = PW'($urandom);
            subset_mask = N'($urandom);
            bad = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if ({cipher_text_top, cipher_text_bot} !== cap || in_ready || !out_valid || pk_rd_en) bad++;
            end
            check("backpressure_hold_errs", 64'(bad), 0);
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("post_handshake_ready", {62'd0, in_ready, out_valid}, 64'b10);
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int found;
        #3;
        check("reset_state", {in_ready, busy, out_valid, pk_rd_en, pk_addr, cipher_text_top, cipher_text_bot},
              64'(29'h1000_0000));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_txn({N{1'b1}}, 6'd0, 1'b0);
        do_txn('0, 6'd5, 1'b0);
        do_txn(30'h2000_0001, 6'd63, 1'b0);
        for (int r = 0; r < 6; r++) do_txn(N'($urandom), PW'($urandom), 1'b0);
        do_txn(N'($urandom), PW'($urandom), 1'b1);

        launch({N{1'b1}}, 6'd0, 1'b0);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clk);
            if (pk_rd_en && pk_addr == AW'(12)) found = 1;
        end
        check("reset_trigger_seen", 64'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_issue", {in_ready, busy, out_valid, pk_rd_en, pk_addr, cipher_text_top, cipher_text_bot},
              64'(29'h1000_0000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn({N{1'b1}}, 6'd1, 1'b0);
        do_txn(N'($urandom), PW'($urandom), 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
